// File: rtl/iob_dbus_split.sv
// Address-decoding splitter for the CPU native data bus: routes each request to one
// slave by an address select field and returns reads from the slave that owns them.
module iob_dbus_split #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 2,
  parameter int SEL_W    = 1,
  parameter int P_SEL    = ADDR_W - 2,
  localparam int WSTRB_W = DATA_W / 8,
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + WSTRB_W,
  localparam int RESP_W  = DATA_W + 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cke_i,
  input  logic [REQ_W-1:0]           m_req,
  output logic [RESP_W-1:0]          m_resp,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  output logic                       pend_o,
  output logic                       err_o
);

  localparam int ADDR_LSB = DATA_W + WSTRB_W;
  localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N_SLAVES);

  logic              m_avalid;
  logic              is_read;
  logic [SEL_W-1:0]  sel;
  logic              mapped;
  logic              fwd_ok;
  logic              accept;

  logic              pend;
  logic [SEL_W-1:0]  pend_sel;
  logic              err_pend;
  logic              err;

  logic [N_SLAVES-1:0] s_ready;
  logic [N_SLAVES-1:0] s_rvalid;
  logic [DATA_W-1:0]   s_rdata [N_SLAVES];

  logic              sel_ready;
  logic              pend_rvalid;
  logic [DATA_W-1:0] pend_rdata;

  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  assign m_avalid = m_req[REQ_W-1];
  assign is_read  = (m_req[WSTRB_W-1:0] == '0);
  assign sel      = m_req[ADDR_LSB+P_SEL -: SEL_W];
  assign mapped   = ({1'b0, sel} < N_SEL);
  assign fwd_ok   = !pend && !err_pend;
  assign accept   = m_avalid && m_ready;

  // Only the selected slave ever sees avalid; the payload is broadcast to all of them.
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_slave
    assign s_ready[k]  = s_resp[k*RESP_W];
    assign s_rvalid[k] = s_resp[k*RESP_W+1];
    assign s_rdata[k]  = s_resp[k*RESP_W+2 +: DATA_W];
    assign s_req[k*REQ_W +: REQ_W] =
      {m_avalid && fwd_ok && (sel == SEL_W'(k)), m_req[REQ_W-2:0]};
  end

  always_comb begin
    sel_ready   = 1'b0;
    pend_rvalid = 1'b0;
    pend_rdata  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_ready = s_ready[k];
      end
      if (pend_sel == SEL_W'(k)) begin
        pend_rvalid = s_rvalid[k];
        pend_rdata  = s_rdata[k];
      end
    end
  end

  // Unmapped requests are answered locally; pend/err_pend are mutually exclusive.
  always_comb begin
    m_ready  = m_avalid && fwd_ok && (mapped ? sel_ready : 1'b1);
    m_rvalid = 1'b0;
    m_rdata  = '0;
    if (pend) begin
      m_rvalid = pend_rvalid;
      m_rdata  = pend_rdata;
    end else if (err_pend) begin
      m_rvalid = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend     <= 1'b0;
      pend_sel <= '0;
      err_pend <= 1'b0;
      err      <= 1'b0;
    end else if (cke_i) begin
      if (pend && pend_rvalid) begin
        pend <= 1'b0;
      end
      if (err_pend) begin
        err_pend <= 1'b0;
      end
      if (accept) begin
        if (!mapped) begin
          err <= 1'b1;
          if (is_read) begin
            err_pend <= 1'b1;
          end
        end else if (is_read) begin
          pend     <= 1'b1;
          pend_sel <= sel;
        end
      end
    end
  end

  assign m_resp = {m_rdata, m_rvalid, m_ready};
  assign pend_o = pend;
  assign err_o  = err;

endmodule
